// File: rtl/rf_pkg.sv
// Shared constants, state encoding and frame payload type for the RF command framer.
package rf_pkg;

    localparam logic [7:0]  RF_HEADER = 8'hA5;
    localparam int unsigned SHORT_LEN = 4;
    localparam int unsigned LONG_LEN  = 9;
    localparam logic [3:0]  SHORT_LAST = 4'(SHORT_LEN - 1);
    localparam logic [3:0]  LONG_LAST  = 4'(LONG_LEN - 1);

    localparam logic CMD_SHORT = 1'b0;
    localparam logic CMD_LONG  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0001,
        ST_WAIT_TX  = 4'b0010,
        ST_SET_MODE = 4'b0100,
        ST_WRITE    = 4'b1000
    } state_e;

    typedef struct packed {
        logic        typ;
        logic [7:0]  code;
        logic [47:0] param;
        logic [7:0]  cksum;
    } frame_t;

    // Byte at position idx of the serialised frame; long payload goes MSB byte first.
    function automatic logic [7:0] frame_byte(input frame_t f, input logic [7:0] hdr,
                                              input logic [3:0] idx);
        logic [7:0] b;
        logic [5:0] sh;
        b  = f.cksum;
        sh = {3'd7 - idx[2:0], 3'b000};
        if (idx == 4'd0) begin
            b = hdr;
        end else if (idx == 4'd1) begin
            b = f.code;
        end else if (f.typ == CMD_SHORT) begin
            if (idx == 4'd2) b = f.param[7:0];
        end else if (idx < LONG_LAST) begin
            b = 8'(f.param >> sh);
        end
        return b;
    endfunction

endpackage

// File: rtl/rf_frame_gen.sv
// Serialises RF commands into header/payload/checksum byte frames for the TX FIFO and
// keeps the transmitter's short/long frame mode in step with the frames written.
module rf_frame_gen
    import rf_pkg::*;
#(
    parameter logic [7:0]  HEADER      = RF_HEADER,
    parameter int unsigned QUAL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cmd_vld,
    input  logic        i_cmd_type,
    input  logic [7:0]  i_cmd_code,
    input  logic [47:0] i_cmd_param,
    output logic        o_cmd_rdy,
    input  logic        i_fifo_full,
    input  logic        i_fifo_empty,
    input  logic        i_tx_busy,
    output logic        o_fifo_wr_en,
    output logic [7:0]  o_fifo_wr_data,
    output logic        o_init,
    output logic        o_stop,
    output logic        o_frame_done
);

    localparam int unsigned QW = (QUAL_CYCLES > 1) ? $clog2(QUAL_CYCLES) : 1;

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    frame_t          frame_q, frame_d;
    logic [3:0]      idx_q, idx_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic            rdy_q, init_q, stop_q, done_q;
    logic            done_d;
    logic            wr_en_c;
    logic [7:0]      cksum_c;
    logic [3:0]      last_c;

    // Next-state, checksum and write-strobe logic.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        qcnt_d  = qcnt_q;
        done_d  = 1'b0;

        cksum_c = i_cmd_code + i_cmd_param[7:0];
        if (i_cmd_type == CMD_LONG) begin
            cksum_c = cksum_c + i_cmd_param[47:40] + i_cmd_param[39:32]
                    + i_cmd_param[31:24] + i_cmd_param[23:16] + i_cmd_param[15:8];
        end

        last_c  = (frame_q.typ == CMD_LONG) ? LONG_LAST : SHORT_LAST;
        wr_en_c = (state_q == ST_WRITE) && !i_fifo_full && !rst;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_vld && rdy_q) begin
                    frame_d = '{typ: i_cmd_type, code: i_cmd_code,
                                param: i_cmd_param, cksum: cksum_c};
                    idx_d   = 4'd0;
                    qcnt_d  = '0;
                    state_d = (i_cmd_type == mode_q) ? ST_WRITE : ST_WAIT_TX;
                end
            end
            // Mode may only change once the FIFO has drained and the transmitter is idle.
            ST_WAIT_TX: begin
                if (i_fifo_empty && !i_tx_busy) begin
                    if (qcnt_q == QW'(QUAL_CYCLES - 1)) begin
                        qcnt_d  = '0;
                        state_d = ST_SET_MODE;
                    end else begin
                        qcnt_d = qcnt_q + QW'(1);
                    end
                end else begin
                    qcnt_d = '0;
                end
            end
            ST_SET_MODE: begin
                mode_d  = frame_q.typ;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (wr_en_c) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == last_c) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= CMD_SHORT;
            frame_q <= '0;
            idx_q   <= 4'd0;
            qcnt_q  <= '0;
            rdy_q   <= 1'b0;
            init_q  <= 1'b0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            qcnt_q  <= qcnt_d;
            rdy_q   <= (state_d == ST_IDLE);
            init_q  <= (state_d == ST_SET_MODE) && (frame_d.typ == CMD_LONG);
            stop_q  <= (state_d == ST_SET_MODE) && (frame_d.typ == CMD_SHORT);
            done_q  <= done_d;
        end
    end

    assign o_cmd_rdy      = rdy_q;
    assign o_init         = init_q;
    assign o_stop         = stop_q;
    assign o_frame_done   = done_q;
    assign o_fifo_wr_en   = wr_en_c;
    assign o_fifo_wr_data = ((state_q == ST_WRITE) && !rst) ? frame_byte(frame_q, HEADER, idx_q)
                                                            : 8'h00;

endmodule

// File: doc/rf_frame_gen.md
# rf_frame_gen

Command-to-byte framer placed directly upstream of the RF UART transmitter's byte FIFO. Accepts one RF command per handshake, serialises it into a fixed-length byte frame with header and checksum, and writes the bytes into the TX FIFO. It also drives the transmitter's frame-length mode (short 4-byte / long 9-byte) via `init`/`stop` pulses, so FIFO contents always match the transmitter's byte count per frame.

## Interface
Parameters:
- `HEADER`, 8'hA5, first byte of every frame
- `QUAL_CYCLES`, 2, consecutive cycles of (FIFO empty and transmitter not busy) required before a mode change

Ports:
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `i_cmd_vld` in 1: command request, accepted when `o_cmd_rdy`=1 at the same edge
- `i_cmd_type` in 1: 0 = short frame (4 B), 1 = long frame (9 B)
- `i_cmd_code` in 8: command code byte
- `i_cmd_param` in 48: payload; short uses [7:0], long uses [47:0] MSB byte first
- `o_cmd_rdy` out 1: high only in IDLE
- `i_fifo_full` in 1: TX FIFO full
- `i_fifo_empty` in 1: TX FIFO empty
- `i_tx_busy` in 1: transmitter busy
- `o_fifo_wr_en` out 1: FIFO write strobe
- `o_fifo_wr_data` out 8: FIFO write byte
- `o_init` out 1: one-cycle pulse, switch transmitter to long mode
- `o_stop` out 1: one-cycle pulse, switch transmitter to short mode
- `o_frame_done` out 1: one-cycle pulse after last byte written

## Operation
- States: IDLE, WAIT_TX, SET_MODE, WRITE.
- Internal `mode_r` mirrors transmitter mode; reset 0 (short).
- IDLE: on accept, latch type/code/param, compute checksum, clear byte index. If type == `mode_r` -> WRITE, else -> WAIT_TX.
- WAIT_TX: qualifier counter increments while `i_fifo_empty && !i_tx_busy`, clears otherwise; at `QUAL_CYCLES` -> SET_MODE.
- SET_MODE: one cycle; asserts `o_init` (type 1) or `o_stop` (type 0); `mode_r` <= type; -> WRITE.
- WRITE: `o_fifo_wr_en` = WRITE && !`i_fifo_full` (combinational); `o_fifo_wr_data` = frame byte at index; index increments on each write; after write of last byte (index 3 short, 8 long) -> IDLE with `o_frame_done`.
- Frame short: HEADER, code, param[7:0], cksum. Long: HEADER, code, param[47:40] ... param[7:0], cksum.
- Checksum: 8-bit sum (mod 256) of code and payload bytes; HEADER excluded.
- Reset values: `o_cmd_rdy` 0 during reset, 1 the cycle after; all other outputs 0; state IDLE; `mode_r` 0.
- Boundaries: `i_cmd_vld` while not ready is ignored (no queue). FIFO full stalls WRITE indefinitely with byte held. Reset mid-frame aborts; partial frame is not completed. Mode never changes while a transmitter frame is in flight.

## Timing
- Accept at edge T, no mode change: bytes written T+1..T+4 (short) or T+1..T+9 (long) when not full; IDLE, `o_cmd_rdy`=1, `o_frame_done`=1 at T+5 / T+10.
- Mode change: WAIT_TX from T+1; qualifier true cycles c, c+1 -> SET_MODE at c+2 (pulse), first byte at c+3.
- Each full cycle in WRITE adds exactly one cycle of latency.
- `o_init`/`o_stop` never both high; never high outside SET_MODE.

## Structure
- Shared package `rf_pkg`: HEADER default, frame lengths 4 and 9, state encodings (one-hot, 4 bits), `CMD_SHORT`/`CMD_LONG` constants.
- Single module, no sub-module; checksum is an inline adder.

## Test plan
- Short, mode unchanged: code 0x10, param 0x22 -> bytes A5,10,22,32 on four consecutive cycles, `o_frame_done` next cycle, no init/stop.
- Long after reset: code 0x01, param 0x010203040506, FIFO empty, tx idle -> `o_init` pulse 3 cycles after accept, then A5,01,01,02,03,04,05,06,16.
- Checksum wrap: short code 0xF0, param 0x20 -> cksum 0x10.
- Mode change gating: long command with `i_tx_busy` high 20 cycles -> no `o_init` until 2 cycles of empty & idle; then short command -> `o_stop` pulse, 4-byte frame.
- Full stall: `i_fifo_full` high on third byte for 5 cycles -> byte 3 held, no write strobe, resumes unchanged; `i_cmd_vld` during frame ignored.
- Reset mid long frame after 4 bytes -> outputs 0, `mode_r` 0, next long command re-issues `o_init`.
